// File: rtl/adc_spi_rx.sv
// ---------------------------------------------------------------------------
// adc_spi_rx
// Serial receiver for a conversion-triggered SPI ADC. A start request drops
// cs_n (which also starts the ADC conversion), waits CONV_CYC clk cycles, then
// clocks BITS bits out of the ADC MSB first and presents the captured word.
//
// Parameters
//   HBDIV    : clk cycles per sck half-period (>= 1)
//   BITS     : conversion word width (2..32)
//   CONV_CYC : clk cycles cs_n is held low before the first sck edge (>= 1)
//
// Ports
//   clk   : system clock, rising edge
//   rst   : synchronous active-high reset
//   start : single-cycle request, ignored while busy
//   sdi   : serial data from the ADC (source-synchronous to sck)
//   busy  : high from accepted start until the word is delivered
//   cs_n  : ADC chip select / convert strobe, active low
//   sck   : serial clock to the ADC, idle low
//   dout  : last captured word, held between valid strobes
//   valid : one-cycle strobe, dout updated this cycle
// ---------------------------------------------------------------------------
module adc_spi_rx #(
    parameter int HBDIV    = 1,
    parameter int BITS     = 16,
    parameter int CONV_CYC = 100
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            sdi,
    output logic            busy,
    output logic            cs_n,
    output logic            sck,
    output logic [BITS-1:0] dout,
    output logic            valid
);

    // Counter widths: each counter only has to reach terminal-1, and a
    // terminal count of 1 still needs a one-bit register.
    localparam int CONV_W = (CONV_CYC > 1) ? $clog2(CONV_CYC) : 1;
    localparam int HB_W   = (HBDIV > 1) ? $clog2(HBDIV) : 1;
    localparam int HALF_N = 2 * BITS;
    localparam int HALF_W = $clog2(HALF_N);

    localparam logic [CONV_W-1:0] CONV_LAST = CONV_W'(CONV_CYC - 1);
    localparam logic [CONV_W-1:0] CONV_ONE  = CONV_W'(1);
    localparam logic [HB_W-1:0]   HB_LAST   = HB_W'(HBDIV - 1);
    localparam logic [HB_W-1:0]   HB_ONE    = HB_W'(1);
    localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(HALF_N - 1);
    localparam logic [HALF_W-1:0] HALF_ONE  = HALF_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CONV  = 2'd1,
        ST_SHIFT = 2'd2
    } state_t;

    state_t              state_r;
    logic [CONV_W-1:0]   conv_cnt_r;
    logic [HB_W-1:0]     hb_cnt_r;
    logic [HALF_W-1:0]   half_idx_r;
    logic [BITS-1:0]     shift_r;
    logic [BITS-1:0]     dout_r;
    logic                busy_r;
    logic                cs_n_r;
    logic                sck_r;
    logic                valid_r;

    // Word assembled from the bits captured so far plus the current sdi bit.
    logic [BITS-1:0]     next_word_s;

    assign next_word_s = {shift_r[BITS-2:0], sdi};

    // Transaction sequencer: conversion wait, sck generation, bit capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            conv_cnt_r <= '0;
            hb_cnt_r   <= '0;
            half_idx_r <= '0;
            shift_r    <= '0;
            dout_r     <= '0;
            busy_r     <= 1'b0;
            cs_n_r     <= 1'b1;
            sck_r      <= 1'b0;
            valid_r    <= 1'b0;
        end else begin
            valid_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    sck_r <= 1'b0;
                    if (start) begin
                        state_r    <= ST_CONV;
                        busy_r     <= 1'b1;
                        cs_n_r     <= 1'b0;
                        conv_cnt_r <= '0;
                        shift_r    <= '0;
                    end
                end

                ST_CONV: begin
                    if (conv_cnt_r == CONV_LAST) begin
                        state_r    <= ST_SHIFT;
                        conv_cnt_r <= '0;
                        hb_cnt_r   <= '0;
                        half_idx_r <= '0;
                    end else begin
                        conv_cnt_r <= conv_cnt_r + CONV_ONE;
                    end
                end

                ST_SHIFT: begin
                    if (hb_cnt_r == HB_LAST) begin
                        hb_cnt_r <= '0;
                        // Odd half-periods are the sck-high phases; the edge
                        // that ends one is where the ADC data is stable.
                        if (half_idx_r[0]) begin
                            sck_r   <= 1'b0;
                            shift_r <= next_word_s;
                            if (half_idx_r == HALF_LAST) begin
                                half_idx_r <= '0;
                                state_r    <= ST_IDLE;
                                busy_r     <= 1'b0;
                                cs_n_r     <= 1'b1;
                                dout_r     <= next_word_s;
                                valid_r    <= 1'b1;
                            end else begin
                                half_idx_r <= half_idx_r + HALF_ONE;
                            end
                        end else begin
                            sck_r      <= 1'b1;
                            half_idx_r <= half_idx_r + HALF_ONE;
                        end
                    end else begin
                        hb_cnt_r <= hb_cnt_r + HB_ONE;
                    end
                end

                default: begin
                    state_r    <= ST_IDLE;
                    conv_cnt_r <= '0;
                    hb_cnt_r   <= '0;
                    half_idx_r <= '0;
                    busy_r     <= 1'b0;
                    cs_n_r     <= 1'b1;
                    sck_r      <= 1'b0;
                end
            endcase
        end
    end

    assign busy  = busy_r;
    assign cs_n  = cs_n_r;
    assign sck   = sck_r;
    assign dout  = dout_r;
    assign valid = valid_r;

endmodule

// File: tb/tb_adc_spi_rx.sv
// ---------------------------------------------------------------------------
// tb_adc_spi_rx
// Directed bench for adc_spi_rx. Three instances cover the parameter sets of
// interest: A (BITS=16, HBDIV=2, CONV_CYC=10), B (BITS=16, HBDIV=1,
// CONV_CYC=4) and C (BITS=12, HBDIV=3, CONV_CYC=1). Each instance has an ADC
// model that presents the MSB when cs_n falls and the next bit after every
// sck falling edge. Inputs are driven and outputs sampled on the falling clk.
// ---------------------------------------------------------------------------
module tb_adc_spi_rx;

    logic clk = 1'b0;
    logic rst;
    logic start_a, start_b, start_c;
    logic sdi_a, sdi_b, sdi_c;
    logic busy_a, busy_b, busy_c;
    logic cs_n_a, cs_n_b, cs_n_c;
    logic sck_a, sck_b, sck_c;
    logic valid_a, valid_b, valid_c;
    logic [15:0] dout_a, dout_b;
    logic [11:0] dout_c;

    logic [15:0] word_a, word_b, m_a, m_b;
    logic [11:0] word_c, m_c;

    int checks = 0;
    int errors = 0;
    int rise_a = 0, rise_c = 0;
    int vcnt_a = 0;

    always #5 clk = ~clk;

    adc_spi_rx #(.HBDIV(2), .BITS(16), .CONV_CYC(10)) u_a (
        .clk(clk), .rst(rst), .start(start_a), .sdi(sdi_a), .busy(busy_a),
        .cs_n(cs_n_a), .sck(sck_a), .dout(dout_a), .valid(valid_a));

    adc_spi_rx #(.HBDIV(1), .BITS(16), .CONV_CYC(4)) u_b (
        .clk(clk), .rst(rst), .start(start_b), .sdi(sdi_b), .busy(busy_b),
        .cs_n(cs_n_b), .sck(sck_b), .dout(dout_b), .valid(valid_b));

    adc_spi_rx #(.HBDIV(3), .BITS(12), .CONV_CYC(1)) u_c (
        .clk(clk), .rst(rst), .start(start_c), .sdi(sdi_c), .busy(busy_c),
        .cs_n(cs_n_c), .sck(sck_c), .dout(dout_c), .valid(valid_c));

    // ADC models: load on cs_n fall, advance after each sck fall.
    always begin
        @(negedge cs_n_a); #1; m_a = word_a; sdi_a = m_a[15];
        while (cs_n_a === 1'b0) begin
            @(negedge sck_a or posedge cs_n_a); #1;
            m_a = {m_a[14:0], 1'b0}; sdi_a = m_a[15];
        end
    end

    always begin
        @(negedge cs_n_b); #1; m_b = word_b; sdi_b = m_b[15];
        while (cs_n_b === 1'b0) begin
            @(negedge sck_b or posedge cs_n_b); #1;
            m_b = {m_b[14:0], 1'b0}; sdi_b = m_b[15];
        end
    end

    always begin
        @(negedge cs_n_c); #1; m_c = word_c; sdi_c = m_c[11];
        while (cs_n_c === 1'b0) begin
            @(negedge sck_c or posedge cs_n_c); #1;
            m_c = {m_c[10:0], 1'b0}; sdi_c = m_c[11];
        end
    end

    always @(posedge sck_a) rise_a++;
    always @(posedge sck_c) rise_c++;
    always @(posedge clk) if (valid_a === 1'b1) vcnt_a++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Wait for A to finish; optionally pulse start while busy.
    task automatic wait_a(input bit spam, output int cyc, output bit moved);
        logic [15:0] held;
        held  = dout_a;
        cyc   = 0;
        moved = 1'b0;
        while (busy_a === 1'b1 && cyc < 1000) begin
            cyc++;
            if (dout_a !== held) moved = 1'b1;
            start_a = spam && (cyc == 5 || cyc == 20 || cyc == 33 || cyc == 50 || cyc == 73);
            @(negedge clk);
        end
        start_a = 1'b0;
    endtask

    task automatic wait_b(output int cyc);
        cyc = 0;
        while (busy_b === 1'b1 && cyc < 1000) begin
            cyc++;
            @(negedge clk);
        end
    endtask

    // sck phase tracking for C
    int run_c = 0, prev_c = 0, nh_c = 0, nl_c = 0, badh_c = 0, badl_c = 0;
    bit seen_h = 1'b0;

    task automatic track_c(input logic s);
        if (int'(s) == prev_c) begin
            run_c++;
        end else begin
            if (prev_c == 1) begin
                nh_c++;
                if (run_c != 3) badh_c++;
                seen_h = 1'b1;
            end else if (seen_h) begin
                nl_c++;
                if (run_c != 3) badl_c++;
            end
            prev_c = int'(s);
            run_c  = 1;
        end
    endtask

    initial begin
        int cyc;
        int snap;
        int vsnap;
        bit moved;

        rst = 1'b1;
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        word_a = 16'h0000; word_b = 16'h0000; word_c = 12'h000;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_busy",  32'(busy_a),  32'd0);
        check("rst_cs_n",  32'(cs_n_a),  32'd1);
        check("rst_sck",   32'(sck_a),   32'd0);
        check("rst_valid", 32'(valid_a), 32'd0);
        check("rst_dout",  32'(dout_a),  32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Basic read of 0xA5C3
        word_a = 16'hA5C3;
        snap = rise_a;
        vsnap = vcnt_a;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        check("a5_busy_on", 32'(busy_a), 32'd1);
        check("a5_cs_low",  32'(cs_n_a), 32'd0);
        wait_a(1'b0, cyc, moved);
        check("a5_busy_len", 32'(cyc), 32'd74);
        check("a5_valid",    32'(valid_a), 32'd1);
        check("a5_dout",     32'(dout_a), 32'hA5C3);
        check("a5_cs_high",  32'(cs_n_a), 32'd1);
        check("a5_rises",    32'(rise_a - snap), 32'd16);
        check("a5_hold",     32'(moved), 32'd0);
        @(negedge clk);
        check("a5_valid_1cyc", 32'(valid_a), 32'd0);
        check("a5_vcount",     32'(vcnt_a - vsnap), 32'd1);

        // Extra start pulses while busy are ignored
        word_a = 16'h3C5A;
        vsnap = vcnt_a;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        wait_a(1'b1, cyc, moved);
        check("spam_busy_len", 32'(cyc), 32'd74);
        check("spam_dout",     32'(dout_a), 32'h3C5A);
        check("spam_hold",     32'(moved), 32'd0);
        @(negedge clk);
        check("spam_idle",   32'(busy_a), 32'd0);
        check("spam_vcount", 32'(vcnt_a - vsnap), 32'd1);

        // Abort at the 8th sck rising edge
        word_a = 16'h5555;
        vsnap = vcnt_a;
        snap = rise_a;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        cyc = 0;
        while ((rise_a - snap) < 8 && cyc < 300) begin
            cyc++;
            @(negedge clk);
        end
        check("abort_rises", 32'(rise_a - snap), 32'd8);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_cs_n", 32'(cs_n_a), 32'd1);
        check("abort_sck",  32'(sck_a),  32'd0);
        check("abort_busy", 32'(busy_a), 32'd0);
        check("abort_dout", 32'(dout_a), 32'd0);
        repeat (3) @(negedge clk);
        check("abort_no_valid", 32'(vcnt_a - vsnap), 32'd0);
        word_a = 16'h1234;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        wait_a(1'b0, cyc, moved);
        check("post_abort_len",  32'(cyc), 32'd74);
        check("post_abort_dout", 32'(dout_a), 32'h1234);
        check("post_abort_valid", 32'(valid_a), 32'd1);
        @(negedge clk);

        // rst wins over start
        rst = 1'b1;
        start_a = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        start_a = 1'b0;
        check("rst_start_busy", 32'(busy_a), 32'd0);
        check("rst_start_cs_n", 32'(cs_n_a), 32'd1);
        @(negedge clk);
        check("rst_start_cs_n2", 32'(cs_n_a), 32'd1);
        check("rst_start_busy2", 32'(busy_a), 32'd0);

        // HBDIV=1 back-to-back
        word_b = 16'hFFFF;
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        wait_b(cyc);
        check("b1_busy_len", 32'(cyc), 32'd36);
        check("b1_valid",    32'(valid_b), 32'd1);
        check("b1_dout",     32'(dout_b), 32'hFFFF);
        check("b1_cs_high",  32'(cs_n_b), 32'd1);
        word_b = 16'h0000;
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        check("b2_cs_low",  32'(cs_n_b), 32'd0);
        check("b2_busy_on", 32'(busy_b), 32'd1);
        check("b2_dout_held", 32'(dout_b), 32'hFFFF);
        wait_b(cyc);
        check("b2_busy_len", 32'(cyc), 32'd36);
        check("b2_valid",    32'(valid_b), 32'd1);
        check("b2_dout",     32'(dout_b), 32'h0000);
        @(negedge clk);

        // BITS=12, HBDIV=3, CONV_CYC=1
        word_c = 12'h9A5;
        snap = rise_c;
        start_c = 1'b1;
        @(negedge clk);
        start_c = 1'b0;
        prev_c = 0;
        run_c = 0;
        cyc = 0;
        while (busy_c === 1'b1 && cyc < 1000) begin
            cyc++;
            track_c(sck_c);
            @(negedge clk);
        end
        track_c(sck_c);
        check("c_busy_len", 32'(cyc), 32'd73);
        check("c_valid",    32'(valid_c), 32'd1);
        check("c_dout",     32'(dout_c), 32'h9A5);
        check("c_rises",    32'(rise_c - snap), 32'd12);
        check("c_high_runs", 32'(nh_c), 32'd12);
        check("c_low_runs",  32'(nl_c), 32'd11);
        check("c_high_len_bad", 32'(badh_c), 32'd0);
        check("c_low_len_bad",  32'(badl_c), 32'd0);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/adc_spi_rx.md
ADC_SPI_RX -- requirements
Module: adc_spi_rx

Interface
REQ-001 Parameter HBDIV, default 1: clk cycles per SCK half-period; legal range >= 1.
REQ-002 Parameter BITS, default 16: conversion word width, MSB first; legal range 2..32.
REQ-003 Parameter CONV_CYC, default 100: clk cycles cs_n is held low before the first SCK edge (ADC conversion time); legal range >= 1.
REQ-004 clk  input  1  system clock; all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 start  input  1  single-cycle request to run one conversion-and-read.
REQ-007 sdi  input  1  serial data from ADC, used directly (source-synchronous to sck, no synchronizer).
REQ-008 busy  output  1  high from accepted start until word delivered.
REQ-009 cs_n  output  1  ADC chip select / convert strobe, active-low.
REQ-010 sck  output  1  serial clock to ADC, idle low.
REQ-011 dout  output  BITS  last captured word.
REQ-012 valid  output  1  one-cycle strobe, dout updated this cycle.

Function
REQ-013 All outputs registered; states IDLE, CONV, SHIFT.
REQ-014 IDLE: start=1 at a clk edge -> at that edge state<=CONV, busy<=1, cs_n<=0, conversion counter cleared; sck stays 0.
REQ-015 start with busy=1 ignored, no effect on timing or data.
REQ-016 CONV: lasts exactly CONV_CYC clk cycles with cs_n=0, sck=0; then state<=SHIFT, half-bit counter and bit index cleared.
REQ-017 SHIFT: 2*BITS half-periods of HBDIV cycles each; even half-periods sck=0, odd half-periods sck=1 (BITS rising edges total).
REQ-018 At the clk edge ending each high half-period (the edge driving sck 1->0), sdi shifted into the capture register LSB side, first sample lands in bit BITS-1 of the final word.
REQ-019 At the edge ending the last high half-period: sck<=0, cs_n<=1, busy<=0, dout<=complete word, valid<=1, state<=IDLE.
REQ-020 busy high for exactly CONV_CYC + 2*BITS*HBDIV cycles per transaction; valid high exactly 1 cycle, the cycle after busy falls.
REQ-021 start accepted in the valid cycle (busy=0) -> new transaction begins; cs_n high minimum 1 cycle between transactions.
REQ-022 dout holds its value between valid strobes; never changes mid-transaction.
REQ-023 Counters sized $clog2 of their terminal count, wrap to 0 at terminal count only; no overflow for any legal parameter.
REQ-024 HBDIV=1: sck toggles every clk cycle, sck frequency clk/2; behaviour otherwise identical.

Reset
REQ-025 rst=1 at any edge -> state IDLE, busy=0, cs_n=1, sck=0, valid=0, dout=0, capture register and all counters 0.
REQ-026 rst has priority over start in the same cycle; start ignored.
REQ-027 rst mid-CONV or mid-SHIFT aborts: no valid strobe, partial word discarded, cs_n high and sck low the cycle after the rst edge.

Verification
REQ-028 BITS=16, HBDIV=2, CONV_CYC=10, ADC model drives 0xA5C3 on sck falling edges -> exactly 16 sck rising edges, busy high 74 cycles, valid 1 cycle, dout=0xA5C3.
REQ-029 HBDIV=1, model drives 0xFFFF then 0x0000 back-to-back (second start in valid cycle) -> dout=0xFFFF then 0x0000, cs_n high exactly 1 cycle between.
REQ-030 start pulsed 5 times during busy -> single transaction, busy duration unchanged, one valid strobe.
REQ-031 rst asserted at 8th sck rising edge -> next cycle cs_n=1, sck=0, busy=0, dout=0, no valid; following start reads 0x1234 correctly.
REQ-032 rst and start asserted together from IDLE -> no transaction, cs_n stays 1.
REQ-033 BITS=12, HBDIV=3, CONV_CYC=1, model 0x9A5 -> dout=0x9A5, busy high 73 cycles, sck high/low phases each 3 cycles.
